// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit in the EX stage
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_md_valid,
    input  logic [2:0]      ex_md_op,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic [XLEN-1:0] ex_rs2_val,
    input  logic [4:0]      ex_rd_addr,
    input  logic            md_kill,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic [4:0]      md_rd_addr
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_STEP = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [4:0]          rd_q;
    logic                neg_q;
    logic                neg_r;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     rem;
    logic [5:0]          cnt;
    logic                done_r;

    logic                rs1_signed;
    logic                rs2_signed;
    logic                sign1;
    logic                sign2;
    logic [XLEN-1:0]     abs1;
    logic [XLEN-1:0]     abs2;
    logic                is_div;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     fast_res;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [XLEN-1:0]     rem_nxt;
    logic [XLEN-1:0]     quo_nxt;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quot;
    logic [XLEN-1:0]     remv;
    logic [XLEN-1:0]     final_res;

    assign md_busy = ((state == S_IDLE) && ex_md_valid && !md_kill) || (state == S_CALC);
    assign md_done = done_r && !md_kill;

    always_comb begin
        rs1_signed = (ex_md_op == OP_MULH) || (ex_md_op == OP_MULHSU) ||
                     (ex_md_op == OP_DIV)  || (ex_md_op == OP_REM);
        rs2_signed = (ex_md_op == OP_MULH) || (ex_md_op == OP_DIV) || (ex_md_op == OP_REM);
        sign1      = rs1_signed && ex_rs1_val[XLEN-1];
        sign2      = rs2_signed && ex_rs2_val[XLEN-1];
        abs1       = sign1 ? -ex_rs1_val : ex_rs1_val;
        abs2       = sign2 ? -ex_rs2_val : ex_rs2_val;
        is_div     = ex_md_op[2];
        div_zero   = is_div && (ex_rs2_val == '0);
        div_ovf    = ((ex_md_op == OP_DIV) || (ex_md_op == OP_REM)) &&
                     (ex_rs1_val == MIN_NEG) && (ex_rs2_val == '1);
        // op[1] selects the remainder forms among the divide ops
        if (div_zero) begin
            fast_res = ex_md_op[1] ? ex_rs1_val : '1;
        end else begin
            fast_res = ex_md_op[1] ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt   = {mul_sum, acc[XLEN-1:1]};
        // restoring divide: quotient bits shift in at acc[0] as dividend bits shift out of acc[XLEN-1]
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        rem_nxt   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        quo_nxt   = {acc[XLEN-2:0], ~div_diff[XLEN]};
        prod      = neg_q ? -mul_nxt : mul_nxt;
        quot      = neg_q ? -quo_nxt : quo_nxt;
        remv      = neg_r ? -rem_nxt : rem_nxt;
        case (op_q)
            OP_MUL:                      final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = quot;
            default:                     final_res = remv;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            opnd       <= '0;
            acc        <= '0;
            rem        <= '0;
            cnt        <= '0;
            done_r     <= 1'b0;
            md_result  <= '0;
            md_rd_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (ex_md_valid && !md_kill) begin
                        op_q  <= ex_md_op;
                        rd_q  <= ex_rd_addr;
                        neg_q <= sign1 ^ sign2;
                        neg_r <= sign1;
                        cnt   <= '0;
                        if (div_zero || div_ovf) begin
                            md_result  <= fast_res;
                            md_rd_addr <= ex_rd_addr;
                            done_r     <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            rem   <= '0;
                            state <= S_CALC;
                            if (is_div) begin
                                acc  <= {{XLEN{1'b0}}, abs1};
                                opnd <= abs2;
                            end else begin
                                acc  <= {{XLEN{1'b0}}, abs2};
                                opnd <= abs1;
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (md_kill) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (op_q[2]) begin
                            acc <= {acc[2*XLEN-1:XLEN], quo_nxt};
                            rem <= rem_nxt;
                        end else begin
                            acc <= mul_nxt;
                        end
                        if (cnt == LAST_STEP) begin
                            md_result  <= final_res;
                            md_rd_addr <= rd_q;
                            done_r     <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_md_valid;
    logic [2:0]  ex_md_op;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [4:0]  ex_rd_addr;
    logic        md_kill;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;
    logic [4:0]  md_rd_addr;

    int checks = 0;
    int failures = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_md_valid(ex_md_valid),
        .ex_md_op   (ex_md_op),
        .ex_rs1_val (ex_rs1_val),
        .ex_rs2_val (ex_rs2_val),
        .ex_rd_addr (ex_rd_addr),
        .md_kill    (md_kill),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_result  (md_result),
        .md_rd_addr (md_rd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat counts cycles from the start edge to the md_done cycle; busy_n counts busy cycles incl. start cycle
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int busy_n,
                          output logic [31:0] res, output logic [4:0] rdo);
        @(negedge clk);
        ex_md_valid = 1'b1;
        ex_md_op    = op;
        ex_rs1_val  = a;
        ex_rs2_val  = b;
        ex_rd_addr  = rd;
        #1;
        busy_n = md_busy ? 1 : 0;
        @(negedge clk);
        ex_md_valid = 1'b0;
        ex_rs1_val  = ~a;
        ex_rs2_val  = ~b;
        ex_rd_addr  = ~rd;
        #1;
        for (lat = 1; lat <= 100; lat++) begin
            if (md_done) break;
            if (md_busy) busy_n++;
            @(negedge clk);
            #1;
        end
        res = md_result;
        rdo = md_rd_addr;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        if (md_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", md_done); end
        checks++;
        if (md_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
        checks++;
        if (md_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", md_result); end
        checks++;
        if (md_rd_addr !== 5'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", md_rd_addr); end
        checks++;
    endtask

    task automatic test_mul();
        int lat, bn;
        logic [31:0] res;
        logic [4:0] rdo;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, lat, bn, res, rdo);
        if (res !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        checks++;
        if (bn !== 33) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=33", bn); end
        checks++;
        if (rdo !== 5'd9) begin failures++; $display("FAIL mul_rd got=%0d exp=9", rdo); end
        checks++;
        if (md_busy !== 1'b0) begin failures++; $display("FAIL mul_busy_in_done got=%b exp=0", md_busy); end
        checks++;
        @(negedge clk);
        #1;
        if (md_done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", md_done); end
        checks++;
        if (md_result !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_hold got=%h exp=ffffffeb", md_result); end
        checks++;
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [3] = '{3'd1, 3'd3, 3'd2};
        logic [31:0] va  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ve  [3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        int lat, bn;
        logic [31:0] res;
        logic [4:0] rdo;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], va[i], vb[i], 5'd1, lat, bn, res, rdo);
            if (res !== ve[i]) begin failures++; $display("FAIL mulh_result[%0d] got=%h exp=%h", i, res, ve[i]); end
            checks++;
            if (lat !== 33) begin failures++; $display("FAIL mulh_latency[%0d] got=%0d exp=33", i, lat); end
            checks++;
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] va  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] vb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ve  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        int lat, bn;
        logic [31:0] res;
        logic [4:0] rdo;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], 5'd2, lat, bn, res, rdo);
            if (res !== ve[i]) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, ve[i]); end
            checks++;
            if (lat !== 33) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
            checks++;
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd6};
        logic [31:0] va  [4] = '{32'h80000000, 32'h80000000, 32'd5, 32'd5};
        logic [31:0] vb  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] ve  [4] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd5};
        int lat, bn;
        logic [31:0] res;
        logic [4:0] rdo;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], 5'd3, lat, bn, res, rdo);
            if (res !== ve[i]) begin failures++; $display("FAIL fast_result[%0d] got=%h exp=%h", i, res, ve[i]); end
            checks++;
            if (lat !== 1) begin failures++; $display("FAIL fast_latency[%0d] got=%0d exp=1", i, lat); end
            checks++;
            if (bn !== 1) begin failures++; $display("FAIL fast_busy[%0d] got=%0d exp=1", i, bn); end
            checks++;
        end
    endtask

    task automatic test_kill();
        int lat, bn, done_seen;
        logic [31:0] res;
        logic [4:0] rdo;
        done_seen = 0;
        @(negedge clk);
        ex_md_valid = 1'b1;
        ex_md_op    = 3'd4;
        ex_rs1_val  = 32'd1000;
        ex_rs2_val  = 32'd3;
        ex_rd_addr  = 5'd4;
        @(negedge clk);
        ex_md_valid = 1'b0;
        repeat (9) @(negedge clk);
        md_kill = 1'b1;
        @(negedge clk);
        md_kill = 1'b0;
        #1;
        if (md_busy !== 1'b0) begin failures++; $display("FAIL kill_busy got=%b exp=0", md_busy); end
        checks++;
        if (md_result !== 32'd5) begin failures++; $display("FAIL kill_result_hold got=%h exp=5", md_result); end
        checks++;
        for (int i = 0; i < 40; i++) begin
            if (md_done) done_seen++;
            @(negedge clk);
            #1;
        end
        if (done_seen !== 0) begin failures++; $display("FAIL kill_no_done got=%0d exp=0", done_seen); end
        checks++;
        run_op(3'd0, 32'd3, 32'd4, 5'd5, lat, bn, res, rdo);
        if (res !== 32'd12) begin failures++; $display("FAIL kill_next_mul got=%h exp=c", res); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL kill_next_latency got=%0d exp=33", lat); end
        checks++;
    endtask

    task automatic test_reset_mid_calc();
        int lat, bn;
        logic [31:0] res;
        logic [4:0] rdo;
        @(negedge clk);
        ex_md_valid = 1'b1;
        ex_md_op    = 3'd5;
        ex_rs1_val  = 32'd100;
        ex_rs2_val  = 32'd7;
        ex_rd_addr  = 5'd6;
        @(negedge clk);
        ex_md_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (md_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", md_busy); end
        checks++;
        if (md_done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", md_done); end
        checks++;
        if (md_result !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", md_result); end
        checks++;
        if (md_rd_addr !== 5'h0) begin failures++; $display("FAIL rst_mid_rd got=%h exp=0", md_rd_addr); end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd5, 32'd9, 32'd3, 5'd7, lat, bn, res, rdo);
        if (res !== 32'd3) begin failures++; $display("FAIL rst_divu_result got=%h exp=3", res); end
        checks++;
        if (lat !== 33) begin failures++; $display("FAIL rst_divu_latency got=%0d exp=33", lat); end
        checks++;
        if (rdo !== 5'd7) begin failures++; $display("FAIL rst_divu_rd got=%0d exp=7", rdo); end
        checks++;
    endtask

    initial begin
        rst_n       = 1'b0;
        ex_md_valid = 1'b0;
        ex_md_op    = 3'd0;
        ex_rs1_val  = 32'h0;
        ex_rs2_val  = 32'h0;
        ex_rd_addr  = 5'h0;
        md_kill     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_fast_path();
        test_kill();
        test_reset_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
